// File: rtl/mem_pkg.sv
// Shared definitions for the ROM-to-RAM block-copy engine: default widths and FSM state encoding.
package mem_pkg;

  localparam int unsigned DEF_D_WIDTH = 8;
  localparam int unsigned DEF_A_WIDTH = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COPY   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_VDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/mem_addr_gen.sv
// Shared index counter for the copy and verify passes: produces base+index for two bases
// (wrapping at 2**A_WIDTH) and flags the final index of a len-word pass.
module mem_addr_gen
  import mem_pkg::*;
#(
  parameter int unsigned A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  input  logic [A_WIDTH:0]   len_i,
  input  logic [A_WIDTH-1:0] base_a_i,
  input  logic [A_WIDTH-1:0] base_b_i,
  output logic [A_WIDTH-1:0] addr_a_o,
  output logic [A_WIDTH-1:0] addr_b_o,
  output logic               last_o
);

  localparam logic [A_WIDTH:0] One = {{A_WIDTH{1'b0}}, 1'b1};

  logic [A_WIDTH:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (adv_i) begin
      idx_d = idx_q + One;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Truncating the index gives the modulo-depth wrap for free.
  assign addr_a_o = base_a_i + idx_q[A_WIDTH-1:0];
  assign addr_b_o = base_b_i + idx_q[A_WIDTH-1:0];
  assign last_o   = (idx_q == (len_i - One));

endmodule

// File: rtl/mem_copy_ctrl.sv
// ROM-to-RAM block-copy engine with one-cycle write pipeline.
// Optional read-back verify pass is compiled in with MEM_COPY_VERIFY_EN.
module mem_copy_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned D_WIDTH = DEF_D_WIDTH,
  parameter int unsigned A_WIDTH = DEF_A_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] src_base,
  input  logic [A_WIDTH-1:0] dst_base,
  input  logic [A_WIDTH:0]   len,
  output logic [A_WIDTH-1:0] rom_addr,
  input  logic [D_WIDTH-1:0] rom_data,
  output logic [A_WIDTH-1:0] ram_waddr,
  output logic [D_WIDTH-1:0] ram_wdata,
  output logic               ram_wen,
  output logic [A_WIDTH-1:0] ram_raddr,
  input  logic [D_WIDTH-1:0] ram_rdata,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH:0]   err_cnt,
  output logic [A_WIDTH-1:0] last_addr
);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] src_q, src_d;
  logic [A_WIDTH-1:0] dst_q, dst_d;
  logic [A_WIDTH:0]   len_q, len_d;
  logic               wen_q, wen_d;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic [A_WIDTH-1:0] last_addr_q;
  logic [A_WIDTH-1:0] rom_hold_q;
  logic               accept;
  logic               gen_clr, gen_adv, gen_last;
  logic [A_WIDTH-1:0] gen_src, gen_dst;
`ifdef MEM_COPY_VERIFY_EN
  logic               cmp_q, cmp_d;
  logic [A_WIDTH:0]   err_q;
`endif

  assign accept = (state_q == ST_IDLE) && start;

  mem_addr_gen #(
    .A_WIDTH (A_WIDTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (gen_clr),
    .adv_i    (gen_adv),
    .len_i    (len_q),
    .base_a_i (src_q),
    .base_b_i (dst_q),
    .addr_a_o (gen_src),
    .addr_b_o (gen_dst),
    .last_o   (gen_last)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    gen_clr = 1'b0;
    gen_adv = 1'b0;
`ifdef MEM_COPY_VERIFY_EN
    cmp_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          gen_clr = 1'b1;
          state_d = (len != '0) ? ST_COPY : ST_DONE;
        end
      end
      ST_COPY: begin
        gen_adv = 1'b1;
        wen_d   = 1'b1;
        waddr_d = gen_dst;
        if (gen_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        gen_clr = 1'b1;
`ifdef MEM_COPY_VERIFY_EN
        state_d = ST_VERIFY;
`else
        state_d = ST_DONE;
`endif
      end
`ifdef MEM_COPY_VERIFY_EN
      ST_VERIFY: begin
        gen_adv = 1'b1;
        cmp_d   = 1'b1;
        if (gen_last) state_d = ST_VDRAIN;
      end
      ST_VDRAIN: state_d = ST_DONE;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      last_addr_q <= '0;
      rom_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      rom_hold_q <= rom_addr;
      if (wen_q) last_addr_q <= waddr_q;
    end
  end

`ifdef MEM_COPY_VERIFY_EN
  // Compare lags the read by one cycle to match both memories' read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= 1'b0;
      err_q <= '0;
    end else begin
      cmp_q <= cmp_d;
      if (accept) begin
        err_q <= '0;
      end else if (cmp_q && (rom_data != ram_rdata)) begin
        err_q <= err_q + {{A_WIDTH{1'b0}}, 1'b1};
      end
    end
  end

  assign err_cnt   = err_q;
  assign ram_raddr = (state_q == ST_VERIFY) ? gen_dst : '0;
  assign rom_addr  = ((state_q == ST_COPY) || (state_q == ST_VERIFY)) ? gen_src : rom_hold_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign err_cnt      = '0;
  assign ram_raddr    = '0;
  assign rom_addr     = (state_q == ST_COPY) ? gen_src : rom_hold_q;
`endif

  assign ram_wen   = wen_q;
  assign ram_waddr = waddr_q;
  assign ram_wdata = wen_q ? rom_data : '0;
  assign last_addr = last_addr_q;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Self-checking bench for mem_copy_ctrl with behavioural ROM (data = addr ^ 8'hA5) and RAM models.
module tb_mem_copy_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] src_base, dst_base;
  logic [AW:0]   len;
  logic [AW-1:0] rom_addr, ram_waddr, ram_raddr, last_addr;
  logic [DW-1:0] rom_data, ram_wdata, ram_rdata;
  logic          ram_wen, busy, done;
  logic [AW:0]   err_cnt;

  logic          ram_clr = 1'b0;
  logic          corrupt_req = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [DW-1:0] ram [DEPTH];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_copy_ctrl #(
    .D_WIDTH (DW),
    .A_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .len       (len),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done),
    .err_cnt   (err_cnt),
    .last_addr (last_addr)
  );

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return {3'b000, a} ^ 8'hA5;
  endfunction

  always_ff @(posedge clk) begin
    rom_data  <= rom_val(rom_addr);
    ram_rdata <= ram[ram_raddr];
    if (ram_clr) begin
      for (int j = 0; j < DEPTH; j++) ram[j] <= '0;
    end else begin
      if (ram_wen) ram[ram_waddr] <= ram_wdata;
      if (corrupt_req) ram[corrupt_addr] <= ~ram[corrupt_addr];
    end
  end

  function automatic int exp_done(input int n);
    if (n == 0) return 1;
`ifdef MEM_COPY_VERIFY_EN
    return 2 * n + 3;
`else
    return n + 2;
`endif
  endfunction

  function automatic int exp_busy(input int n);
    if (n == 0) return 0;
    return exp_done(n) - 1;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_ram();
    @(negedge clk);
    ram_clr = 1'b1;
    @(negedge clk);
    ram_clr = 1'b0;
  endtask

  // Issues one start and follows the operation to done; optionally spams start while busy and
  // flips RAM word dst+2 at a chosen cycle.
  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                          input bit spam, input int corrupt_cyc, output int done_cyc,
                          output int wen_cnt, output int busy_cnt);
    int extra;
    @(negedge clk);
    src_base = s;
    dst_base = d;
    len      = n;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cyc = -1;
    wen_cnt  = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
      @(negedge clk);
      corrupt_req = 1'b0;
      if (ram_wen) wen_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = k;
        start = 1'b0;
      end else begin
        start = spam;
        if (k == corrupt_cyc) begin
          corrupt_req  = 1'b1;
          corrupt_addr = d + 5'd2;
        end
      end
    end
    start = 1'b0;
    corrupt_req = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || busy || ram_wen) extra++;
    end
    chk("post_done_quiet", extra, 0);
  endtask

  typedef struct {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [AW:0]   n;
    bit            spam;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int dc, wc, bc, bad;
    logic [AW-1:0] a, sa;

    vecs[0] = '{src: 5'h00, dst: 5'h00, n: 6'd32, spam: 1'b0, exp_last: 5'h1F};
    vecs[1] = '{src: 5'h1E, dst: 5'h03, n: 6'd4,  spam: 1'b1, exp_last: 5'h06};
    vecs[2] = '{src: 5'h10, dst: 5'h1C, n: 6'd8,  spam: 1'b0, exp_last: 5'h03};
    vecs[3] = '{src: 5'h07, dst: 5'h09, n: 6'd1,  spam: 1'b1, exp_last: 5'h09};
    vecs[4] = '{src: 5'h0A, dst: 5'h0B, n: 6'd0,  spam: 1'b0, exp_last: 5'h09};

    rst = 1'b1;
    start = 1'b0;
    src_base = '0;
    dst_base = '0;
    len = '0;
    ram_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wen", ram_wen, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_last_addr", last_addr, 0);
    chk("reset_rom_addr", rom_addr, 0);
    rst = 1'b0;
    ram_clr = 1'b0;

    // Reset during a 16-word copy while index 5 is on the ROM address.
    run_reset_abort();

    for (int v = 0; v < 5; v++) begin
      clear_ram();
      run_copy(vecs[v].src, vecs[v].dst, vecs[v].n, vecs[v].spam, -1, dc, wc, bc);
      chk($sformatf("v%0d_done_cycle", v), dc, exp_done(int'(vecs[v].n)));
      chk($sformatf("v%0d_write_count", v), wc, int'(vecs[v].n));
      chk($sformatf("v%0d_busy_cycles", v), bc, exp_busy(int'(vecs[v].n)));
      chk($sformatf("v%0d_last_addr", v), last_addr, vecs[v].exp_last);
      chk($sformatf("v%0d_err_cnt", v), err_cnt, 0);
      bad = 0;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        a  = vecs[v].dst + k[AW-1:0];
        sa = vecs[v].src + k[AW-1:0];
        if (ram[a] != rom_val(sa)) bad++;
      end
      chk($sformatf("v%0d_ram_bad_words", v), bad, 0);
      if (vecs[v].n < 6'd32) begin
        a = vecs[v].dst + vecs[v].n[AW-1:0];
        chk($sformatf("v%0d_ram_outside", v), ram[a], 0);
      end
    end

    // Corrupt RAM[dst+2] after its write but before any read-back.
    clear_ram();
    run_copy(5'h04, 5'h00, 6'd8, 1'b0, 6, dc, wc, bc);
    chk("corrupt_done_cycle", dc, exp_done(8));
`ifdef MEM_COPY_VERIFY_EN
    chk("corrupt_err_cnt", err_cnt, 1);
`else
    chk("corrupt_err_cnt", err_cnt, 0);
`endif
    clear_ram();
    run_copy(5'h04, 5'h00, 6'd8, 1'b0, -1, dc, wc, bc);
    chk("clean_done_cycle", dc, exp_done(8));
    chk("clean_err_cnt", err_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic run_reset_abort();
    int wc, dc, bc;
    clear_ram();
    @(negedge clk);
    src_base = 5'h00;
    dst_base = 5'h00;
    len      = 6'd16;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_pre_wen", ram_wen, 1);
    chk("abort_pre_rom_addr", rom_addr, 5);
    rst = 1'b1;
    #1;
    chk("abort_wen_async", ram_wen, 0);
    chk("abort_busy_async", busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wc = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (ram_wen || busy || done) wc++;
    end
    chk("abort_no_activity", wc, 0);
    run_copy(5'h02, 5'h10, 6'd3, 1'b0, -1, dc, wc, bc);
    chk("abort_restart_done", dc, exp_done(3));
    chk("abort_restart_writes", wc, 3);
    chk("abort_restart_data", ram[5'h12], rom_val(5'h04));
  endtask

endmodule
